memory_access_unit: RTL
=======================

# memory_access_unit

Memory-stage data access unit for the RISC-V pipeline. It consumes the load/store fields held in the execute-to-memory pipeline latch and runs the transaction on the data bus with a request/ready handshake. It handles byte-lane alignment, store strobes and load sign/zero extension, and flags misaligned accesses, bus errors and timeouts. It stalls the pipeline while a transaction is outstanding.

## Interface
- TIMEOUT_CYCLES, 255: ACCESS cycles without `dbus_ready` before the request is abandoned with an access fault (range 1..255).

Ports:
- `CLK`  in  1  clock.
- `nRST`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  latch holds a valid instruction.
- `ex_flush`  in  1  kill the current instruction.
- `ex_dread`  in  1  load.
- `ex_dwrite`  in  2  store width: 0 none, 1 byte, 2 halfword, 3 word.
- `ex_reg_wr_mem`  in  2  load width: 0 byte, 1 halfword, 2 word (3 treated as word).
- `ex_reg_wr_mem_signed`  in  1  1 = sign-extend the load.
- `ex_addr`  in  32  byte address (ALU output).
- `ex_wdata`  in  32  store data (rdat2), right-justified.
- `mem_stall`  out  1  hold the execute-to-memory latch.
- `dbus_req`  out  1  bus request.
- `dbus_wen`  out  1  1 = write.
- `dbus_addr`  out  32  word-aligned address (bits [1:0] = 0).
- `dbus_wdata`  out  32  lane-replicated store data.
- `dbus_strobe`  out  4  byte-enable.
- `dbus_rdata`  in  32  read data, valid with `dbus_ready`.
- `dbus_ready`  in  1  completes the transaction.
- `dbus_error`  in  1  sampled with `dbus_ready`.
- `load_data`  out  32  extended load result.
- `load_valid`  out  1  one-cycle pulse.
- `misaligned`  out  1  one-cycle pulse.
- `access_fault`  out  1  one-cycle pulse.

## Operation
- States: IDLE, ACCESS, DONE.
- Access request: `ex_valid & (ex_dread | ex_dwrite!=0) & !ex_flush`. If the store field is nonzero, it is a store and takes precedence over `ex_dread`.
- Effective width: the store width, or `ex_reg_wr_mem` for loads.
- Misaligned: halfword with `addr[0]=1`, or word with `addr[1:0]!=0`.

State transitions:
- IDLE, aligned request: latch the bus fields and go to ACCESS.
- IDLE, misaligned request: no bus traffic; go to DONE with the misaligned flag set.
- ACCESS: hold `dbus_req=1` and all bus fields constant. When `dbus_ready` is sampled:
  - capture the extended read data;
  - set the fault flag if `dbus_error` is high;
  - go to DONE.
- ACCESS timeout: when the counter reaches TIMEOUT_CYCLES with no ready, drop `dbus_req` and go to DONE with the fault flag set.
- DONE: pulse the registered flags for one cycle, then go to IDLE. In DONE the `ex_*` inputs are ignored, because the same instruction is still latched.

Store lanes:
- Byte: `strobe = 1<<addr[1:0]`, wdata = byte replicated ×4.
- Halfword: strobe = 0011 / 1100 by `addr[1]`, wdata = half replicated ×2.
- Word: strobe = 1111.
- Loads drive strobe 0000 and wdata 0.

Load extraction:
- Byte: `rdata[8*addr[1:0] +: 8]`.
- Halfword: `rdata[16*addr[1] +: 16]`.
- Result is sign- or zero-extended per `ex_reg_wr_mem_signed`.

Output qualification:
- `load_valid` = DONE & load & no fault.
- `misaligned` / `access_fault` are high only in DONE.
- `load_data` holds its value until the next load completes.

Flush:
- `ex_flush` in IDLE or DONE: go to / stay in IDLE, and pulse no outputs.
- `ex_flush` during ACCESS: the bus request is never withdrawn. The transaction completes, then the FSM returns to IDLE with no pulses and no `load_data` update. A flush seen at any ACCESS cycle is remembered.

Reset:
- All outputs 0, state IDLE, counter 0, flush-pending 0.
- Reset mid-ACCESS drops `dbus_req` immediately.

## Timing
- `mem_stall` is combinational: 1 in IDLE when an access request is present, 1 throughout ACCESS, 0 in DONE.
- Bus outputs are registered. `dbus_req` rises the cycle after the request is seen in IDLE.
- Minimum load latency, with the request seen in cycle 0:
  - cycle 1: `dbus_req`=1, and `dbus_ready`=1 is sampled;
  - cycle 2: DONE with `load_valid`=1;
  - the latch advances at the end of cycle 2.
- Misaligned: request in cycle 0, `misaligned` pulse in cycle 1, `mem_stall` high in cycle 0 only.
- Timeout: with the request in cycle 0, `dbus_req` is high for cycles 1..TIMEOUT_CYCLES and `access_fault` pulses in cycle TIMEOUT_CYCLES+1.
- `dbus_ready` outside ACCESS is ignored.
- Non-memory instructions produce no stall and no outputs.

## Test plan
- LB signed, addr 0x1003, rdata 0x80FF_0000, ready on the 1st ACCESS cycle -> `dbus_addr` 0x1000, strobe 0000, `load_data` 0xFFFF_FF80, `load_valid` pulse in cycle 2, stall in cycles 0–1.
- SH, addr 0x2002, wdata 0x1234_ABCD, ready after 3 wait cycles -> `dbus_wen`=1, strobe 1100, `dbus_wdata` 0xABCD_ABCD, bus fields stable throughout, no `load_valid`.
- LW at 0x3001 -> no `dbus_req`, `misaligned` pulse in cycle 1. LHU at 0x3002 with rdata 0xBEEF_0000 -> `load_data` 0x0000_BEEF.
- TIMEOUT_CYCLES=4, ready never asserted -> `dbus_req` high in cycles 1–4, `access_fault` in cycle 5, return to IDLE. Repeating with `dbus_error`=1 on ready -> `access_fault`, no `load_valid`.
- `ex_flush` in ACCESS cycle 2, ready in cycle 4 -> `dbus_req` held through cycle 4, no pulses, `load_data` unchanged.
- `nRST` low mid-ACCESS -> all outputs 0 asynchronously. The next request after reset release completes normally.

Source files
------------

// File: rtl/memory_access_unit.sv
// ============================================================================
// memory_access_unit: memory-stage load/store engine with lane alignment,
// load extension, misalignment, bus error and timeout detection.  Rev 1.0
// ============================================================================
`default_nettype none

module memory_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_valid,
    input  logic        ex_flush,
    input  logic        ex_dread,
    input  logic [1:0]  ex_dwrite,
    input  logic [1:0]  ex_reg_wr_mem,
    input  logic        ex_reg_wr_mem_signed,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        mem_stall,
    output logic        dbus_req,
    output logic        dbus_wen,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_strobe,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ready,
    input  logic        dbus_error,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misaligned,
    output logic        access_fault
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    localparam logic [1:0] W_BYTE       = 2'd0;
    localparam logic [1:0] W_HALF       = 2'd1;
    localparam logic [1:0] W_WORD       = 2'd2;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        flush_pend;
    logic        acc_load;
    logic        acc_signed;
    logic [1:0]  acc_width;
    logic [1:0]  acc_offset;

    logic        is_store;
    logic        access_req;
    logic        misalign;
    logic        flushed;
    logic [1:0]  width;
    logic [3:0]  strobe_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    // A nonzero store field wins over ex_dread.
    assign is_store   = (ex_dwrite != 2'd0);
    assign access_req = ex_valid & (ex_dread | is_store) & ~ex_flush;
    assign flushed    = flush_pend | ex_flush;
    assign mem_stall  = ((state == IDLE) & access_req) | (state == ACCESS);

    always_comb begin
        width       = is_store ? (ex_dwrite - 2'd1)
                               : ((ex_reg_wr_mem == 2'd3) ? W_WORD : ex_reg_wr_mem);
        misalign    = ((width == W_HALF) & ex_addr[0]) |
                      ((width == W_WORD) & (ex_addr[1:0] != 2'b00));
        strobe_next = 4'b0000;
        wdata_next  = 32'h0;
        if (is_store) begin
            case (width)
                W_BYTE: begin
                    strobe_next = 4'b0001 << ex_addr[1:0];
                    wdata_next  = {4{ex_wdata[7:0]}};
                end
                W_HALF: begin
                    strobe_next = ex_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_next  = {2{ex_wdata[15:0]}};
                end
                default: begin
                    strobe_next = 4'b1111;
                    wdata_next  = ex_wdata;
                end
            endcase
        end
    end

    assign byte_sel = dbus_rdata[{acc_offset, 3'b000} +: 8];
    assign half_sel = dbus_rdata[{acc_offset[1], 4'b0000} +: 16];

    always_comb begin
        case (acc_width)
            W_BYTE:  ext_data = {{24{acc_signed & byte_sel[7]}}, byte_sel};
            W_HALF:  ext_data = {{16{acc_signed & half_sel[15]}}, half_sel};
            default: ext_data = dbus_rdata;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            flush_pend   <= 1'b0;
            acc_load     <= 1'b0;
            acc_signed   <= 1'b0;
            acc_width    <= 2'd0;
            acc_offset   <= 2'd0;
            dbus_req     <= 1'b0;
            dbus_wen     <= 1'b0;
            dbus_addr    <= 32'h0;
            dbus_wdata   <= 32'h0;
            dbus_strobe  <= 4'b0000;
            load_data    <= 32'h0;
            load_valid   <= 1'b0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access_req) begin
                        if (misalign) begin
                            misaligned <= 1'b1;
                            state      <= DONE;
                        end else begin
                            dbus_req    <= 1'b1;
                            dbus_wen    <= is_store;
                            dbus_addr   <= {ex_addr[31:2], 2'b00};
                            dbus_wdata  <= wdata_next;
                            dbus_strobe <= strobe_next;
                            acc_load    <= ~is_store;
                            acc_width   <= width;
                            acc_offset  <= ex_addr[1:0];
                            acc_signed  <= ex_reg_wr_mem_signed;
                            wait_cnt    <= 8'd0;
                            flush_pend  <= 1'b0;
                            state       <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // A flushed transaction still runs to completion but reports nothing.
                    flush_pend <= flushed;
                    if (dbus_ready) begin
                        dbus_req <= 1'b0;
                        state    <= DONE;
                        if (!flushed) begin
                            access_fault <= dbus_error;
                            if (acc_load & ~dbus_error) begin
                                load_valid <= 1'b1;
                                load_data  <= ext_data;
                            end
                        end
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        dbus_req     <= 1'b0;
                        access_fault <= ~flushed;
                        state        <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    load_valid   <= 1'b0;
                    misaligned   <= 1'b0;
                    access_fault <= 1'b0;
                    flush_pend   <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
